// File: rtl/updown_counter_bank_if.sv
// Control and status bundle for the up/down counter bank; the bank drives
// count/flags, the user side drives the per-channel controls.
interface updown_counter_bank_if #(
    parameter int COUNT_WIDTH = 5,
    parameter int NUM_CH      = 4,
    parameter int STEP_WIDTH  = 3
);
    logic [NUM_CH-1:0]             en;
    logic [NUM_CH-1:0]             up;
    logic [NUM_CH*STEP_WIDTH-1:0]  step;
    logic [NUM_CH-1:0]             load;
    logic [NUM_CH*COUNT_WIDTH-1:0] load_val;
    logic [NUM_CH-1:0]             clr_flags;
    logic [NUM_CH*COUNT_WIDTH-1:0] count;
    logic [NUM_CH-1:0]             zero;
    logic [NUM_CH-1:0]             max;
    logic [NUM_CH-1:0]             ovf;
    logic [NUM_CH-1:0]             unf;

    modport master (
        output en, up, step, load, load_val, clr_flags,
        input  count, zero, max, ovf, unf
    );

    modport slave (
        input  en, up, step, load, load_val, clr_flags,
        output count, zero, max, ovf, unf
    );
endinterface

// File: rtl/updown_counter_bank.sv
// Bank of independent up/down counters with variable step, parallel load,
// wrap-or-clamp arithmetic and sticky overflow/underflow flags per channel.
module updown_counter_bank #(
    parameter int COUNT_WIDTH = 5,
    parameter int NUM_CH      = 4,
    parameter int STEP_WIDTH  = 3,
    parameter int SATURATE    = 0
) (
    input logic clk,
    input logic rst,
    updown_counter_bank_if.slave bus
);

    localparam logic [COUNT_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [COUNT_WIDTH-1:0] ALL_ZERO = '0;

    // Result MSB is the carry event; low bits are the next count, clamped if SATURATE.
    function automatic logic [COUNT_WIDTH:0] add_step(
        input logic [COUNT_WIDTH-1:0] cnt,
        input logic [STEP_WIDTH-1:0]  stp
    );
        logic [COUNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(COUNT_WIDTH+1-STEP_WIDTH){1'b0}}, stp};
        if (sum[COUNT_WIDTH] && (SATURATE != 0))
            sum = {1'b1, ALL_ONES};
        return sum;
    endfunction

    function automatic logic [COUNT_WIDTH:0] sub_step(
        input logic [COUNT_WIDTH-1:0] cnt,
        input logic [STEP_WIDTH-1:0]  stp
    );
        logic [COUNT_WIDTH:0] diff;
        diff = {1'b0, cnt} - {{(COUNT_WIDTH+1-STEP_WIDTH){1'b0}}, stp};
        if (diff[COUNT_WIDTH] && (SATURATE != 0))
            diff = {1'b1, ALL_ZERO};
        return diff;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [COUNT_WIDTH-1:0] count_p1;
        logic [COUNT_WIDTH-1:0] count_nxt;
        logic [STEP_WIDTH-1:0]  stp;
        logic                   ovf_p1;
        logic                   unf_p1;
        logic                   ovf_set;
        logic                   unf_set;

        assign stp = bus.step[i*STEP_WIDTH +: STEP_WIDTH];

        always_comb begin
            count_nxt = count_p1;
            ovf_set   = 1'b0;
            unf_set   = 1'b0;
            if (bus.load[i]) begin
                count_nxt = bus.load_val[i*COUNT_WIDTH +: COUNT_WIDTH];
            end else if (bus.en[i]) begin
                if (bus.up[i])
                    {ovf_set, count_nxt} = add_step(count_p1, stp);
                else
                    {unf_set, count_nxt} = sub_step(count_p1, stp);
            end
        end

        // Stage p1: registered count and sticky flags; a new event beats clr_flags.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                count_p1 <= '0;
                ovf_p1   <= 1'b0;
                unf_p1   <= 1'b0;
            end else begin
                count_p1 <= count_nxt;
                ovf_p1   <= ovf_set | (ovf_p1 & ~bus.clr_flags[i]);
                unf_p1   <= unf_set | (unf_p1 & ~bus.clr_flags[i]);
            end
        end

        assign bus.count[i*COUNT_WIDTH +: COUNT_WIDTH] = count_p1;
        assign bus.zero[i] = (count_p1 == ALL_ZERO);
        assign bus.max[i]  = (count_p1 == ALL_ONES);
        assign bus.ovf[i]  = ovf_p1;
        assign bus.unf[i]  = unf_p1;
    end

endmodule

// File: doc/updown_counter_bank.md
Name: updown_counter_bank

Overview:
- Bank of NUM_CH independent up/down counters with per-channel variable step, parallel load, and a wrap or saturate mode.
- Each channel has sticky overflow/underflow flags and registered zero/max indicators.
- Parametrised successor to the single-channel up/down counter.
- Used for warp/credit/occupancy tracking, where several counters share one clock domain and need bounded arithmetic.

Parameters:
- COUNT_WIDTH, 5, bits per channel counter.
- NUM_CH, 4, number of independent channels (>=1).
- STEP_WIDTH, 3, bits of per-channel step magnitude (<= COUNT_WIDTH).
- SATURATE, 0, 0 = wrap modulo 2^COUNT_WIDTH; 1 = clamp at 0 / 2^COUNT_WIDTH-1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- en  input  NUM_CH  per-channel count enable
- up  input  NUM_CH  per-channel direction: 1 = up, 0 = down
- step  input  NUM_CH*STEP_WIDTH  per-channel step magnitude; channel i at [i*STEP_WIDTH +: STEP_WIDTH]
- load  input  NUM_CH  per-channel synchronous load strobe
- load_val  input  NUM_CH*COUNT_WIDTH  per-channel load value; channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
- clr_flags  input  NUM_CH  per-channel clear of sticky ovf/unf
- count  output  NUM_CH*COUNT_WIDTH  current counts, registered
- zero  output  NUM_CH  1 when the channel's count == 0
- max  output  NUM_CH  1 when the channel's count == 2^COUNT_WIDTH-1
- ovf  output  NUM_CH  sticky: an up-step crossed the top
- unf  output  NUM_CH  sticky: a down-step crossed below zero

Behaviour:
- Reset:
  - rst low asynchronously forces every count to 0, ovf to 0 and unf to 0, independent of clk.
  - zero = all ones and max = all zeros while in reset.
  - Deassertion takes effect at the next rising clk edge.
  - Reset mid-count discards all state; there is no partial update.
- Channels are fully independent; no cross-channel interaction.
- Per channel, per rising edge, in priority order:
  1. load=1: count <= load_val. en, up and step are ignored. No flag is set.
  2. en=1 and up=1: compute sum = {1'b0,count} + step in COUNT_WIDTH+1 bits.
     - Carry out: ovf <= 1. count <= sum[COUNT_WIDTH-1:0] if SATURATE=0, else all ones.
     - No carry: count <= sum.
  3. en=1 and up=0: compute diff = {1'b0,count} - step in COUNT_WIDTH+1 bits.
     - Borrow (diff[COUNT_WIDTH]=1): unf <= 1. count <= diff[COUNT_WIDTH-1:0] if SATURATE=0, else 0.
     - No borrow: count <= diff.
  4. Otherwise: hold.
- step = 0 with en = 1: count holds and no flag changes.
- Step is zero-extended to COUNT_WIDTH.
- Exact landing is not an overflow/underflow:
  - up from max-step to max: no ovf.
  - down from step to 0: no unf.
- Saturated hold: once saturated at max, further up-steps with step > 0 keep count at max and keep ovf set. The same applies at 0 for unf.
- Sticky flags:
  - clr_flags=1 clears ovf and unf on the next edge.
  - If a new overflow/underflow event occurs in the same cycle as clr_flags, set wins and the flag stays 1.
  - load does not touch the flags.
- Latency:
  - count, ovf and unf update one edge after the input cycle.
  - zero and max are combinational decodes of the registered count, so they are valid in the same cycle as count. No additional latency.
- No X propagation: all state is reset and all next-state paths are fully specified.

Test Plan:
- Reset: drive en=all ones, up=1, step=1 and pulse rst low between edges -> count, ovf and unf go to 0 immediately, zero=4'b1111; after release, ch0 counts 1, 2, 3 on successive edges.
- Wrap (SATURATE=0), ch1:
  - load 29, then up with step=5 -> count=2, ovf[1]=1, other channels unaffected.
  - Next, down with step=3 -> count=31, unf[1]=1.
- Saturate (SATURATE=1), ch2:
  - load 29, up step=5 -> count=31, max[2]=1, ovf[2]=1.
  - Repeat the step -> count stays 31.
  - Load 2, down step=7 -> count=0, zero[2]=1, unf[2]=1.
- Exact boundary, ch3:
  - load 26, up step=5 -> count=31, ovf[3]=0.
  - load 4, down step=4 -> count=0, unf[3]=0.
- Priority and flag race, ch0:
  - load=1 with en=1, up=1, load_val=10 -> count=10.
  - step=0 with en=1 -> count holds at 10.
  - clr_flags=1 in the same cycle as an overflow-causing step (count 30, step 3) -> ovf[0]=1.
  - clr_flags alone on the following cycle -> ovf[0]=0.
- Independence: all four channels active at once with mixed up/down and distinct steps for 100 random cycles -> every channel matches a per-channel reference model each cycle.
